qdec_bin_arbiter: RTL and testbench
===================================

// Module: qdec_bin_arbiter
// PURPOSE
//  Shares the single CABAC binary arithmetic decoding engine between the decoder's
//  syntax sub-FSMs (CU, trafo, TU residual).
//  - Captures each requester's one-cycle dec_run pulse, with its context address
//    and EP flag.
//  - Grants one requester at a time, round-robin, issues the bin to the engine and
//    routes the returned ruiBin to the owning requester only.
//  - Sits between the sub-FSMs and the engine, replacing the per-level
//    dec_run/ctx_addr muxing.
// PARAMETERS
//  NUM_REQ  3   number of requesting sub-FSMs (2..8)
//  ADDR_W   10  context-address width
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous, active-high reset
//  req_run        in   NUM_REQ        per-requester 1-cycle bin-decode request pulse
//  req_ctx_addr   in   NUM_REQ*ADDR_W context address, sampled with req_run[i] (slice i)
//  req_ep         in   NUM_REQ        bypass (EP) mode, sampled with req_run[i]
//  flush          in   1              drop all pending and outstanding requests
//  ctx_addr       out  ADDR_W         context address to engine
//  ctx_addr_vld   out  1              context address valid (same cycle as dec_run)
//  dec_run        out  1              1-cycle decode start pulse to engine
//  EPMode         out  1              EP mode to engine
//  dec_rdy        in   1              engine idle and able to accept dec_run
//  ruiBin         in   1              decoded bin from engine
//  ruiBin_vld     in   1              decoded bin valid, exactly 1 per dec_run
//  bin_out        out  1              returned bin, broadcast to all requesters
//  bin_vld        out  NUM_REQ        one-hot: bin_out belongs to requester i
//  busy           out  1              any request pending, or state != IDLE
//  err_overflow   out  1              sticky: req_run[i] while i already pending
//  err_spurious   out  1              sticky: ruiBin_vld while IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, pending 0, owner 0, rr_ptr 0.
//  Capture: req_run[i] sets pend[i] and latches addr/ep[i] at the clock edge.
//   - Edge-set wins over the same-cycle clear of pend[i] (requester may re-request
//     in the cycle its bin returns).
//   - req_run[i] while pend[i] is already set and not being cleared: keep the
//     original request and set err_overflow.
//  FSM states:
//   IDLE
//    - If flush: clear pend, stay IDLE.
//    - Else if |pend && dec_rdy: owner <= rr pick (first set pend at or after
//      rr_ptr, wrapping).
//    - Register dec_run=1, ctx_addr_vld=1, ctx_addr/EPMode from the owner's slot;
//      go to WAIT_BIN.
//   WAIT_BIN
//    - dec_run and ctx_addr_vld low. ctx_addr/EPMode hold the owner's values.
//    - On ruiBin_vld: bin_out<=ruiBin, bin_vld<=onehot(owner) for 1 cycle,
//      pend[owner]<=0, rr_ptr<=owner+1 (wrap at NUM_REQ), go to IDLE.
//    - flush without ruiBin_vld: go to DRAIN and clear pend.
//    - flush with ruiBin_vld: return the bin and clear all pend.
//   DRAIN
//    - Wait for ruiBin_vld, discard it (bin_vld stays 0), go to IDLE.
//    - Requests captured in DRAIN are kept (flush only clears at its edge).
//  Latency:
//   - req_run in cycle t, engine ready and idle: dec_run high in cycle t+2.
//   - ruiBin_vld in cycle u: bin_vld high in cycle u+1.
//   - Back-to-back grants: next dec_run at the earliest in cycle u+2.
//  ruiBin_vld in IDLE: ignore it and set err_spurious. Error flags clear only on rst.
//  dec_rdy low in IDLE: hold. The pick is re-evaluated every cycle until issue.
//  Fairness: a requester with pend set is granted within NUM_REQ grants.
// STRUCTURE
//  qdec_cabac_package:
//   - t_state_bin_arb enum {IDLE_BARB, WAIT_BIN_BARB, DRAIN_BARB}.
//   - REQ_CU=0, REQ_TRAFO=1, REQ_TU=2 index constants.
//  Sub-module qdec_rr_pick: combinational round-robin picker.
//   - Inputs: pend, rr_ptr. Outputs: found, idx.
//  Everything else (capture regs, FSM, return routing) is in this module.
// TESTING
//  1 Single request: req_run[1] addr=0x05A ep=0 @t, dec_rdy=1 -> dec_run/ctx_addr=0x05A
//    @t+2; ruiBin=1 vld @u -> bin_vld=3'b010, bin_out=1 @u+1.
//  2 Contention: req_run=3'b111 same cycle, engine returns after 3 cycles ->
//    grant order 0,1,2. Then requests 0 and 2 again -> order 0,2 (rr_ptr=0).
//  3 Re-request: req_run[2] in the same cycle as its bin_vld return ->
//    pend[2] stays 1 and a second dec_run follows; err_overflow stays 0.
//  4 Overflow/spurious: req_run[0] twice before grant -> err_overflow=1 and the
//    first addr is issued. ruiBin_vld in IDLE -> err_spurious=1, no bin_vld.
//  5 Flush in WAIT_BIN with 2 pending -> DRAIN, returned bin gives no bin_vld,
//    pend=0, busy=0 one cycle after ruiBin_vld.
//  6 rst mid WAIT_BIN -> all outputs 0 next cycle. A later ruiBin_vld sets
//    err_spurious only.

Source files
------------

// File: rtl/qdec_bin_arbiter_pkg.sv
// Shared types and requester indices for the CABAC bin arbiter.
package qdec_cabac_package;

    typedef enum logic [1:0] {
        IDLE_BARB     = 2'd0,
        WAIT_BIN_BARB = 2'd1,
        DRAIN_BARB    = 2'd2
    } t_state_bin_arb;

    // Requester slot assignment of the syntax sub-FSMs
    localparam int REQ_CU    = 0;
    localparam int REQ_TRAFO = 1;
    localparam int REQ_TU    = 2;

endpackage

// File: rtl/qdec_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or after rr_ptr, wrapping.
module qdec_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    // Scan the pending vector starting at rr_ptr and stop at the first hit
    always_comb begin : p_pick
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && pend[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/qdec_bin_arbiter.sv
// Shares one CABAC bin decoding engine between several syntax sub-FSMs.
// Requests are captured as pulses, granted round-robin, and the decoded bin
// is routed back only to the requester that owns the outstanding decode.
module qdec_bin_arbiter
    import qdec_cabac_package::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_run,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ctx_addr,
    input  logic [NUM_REQ-1:0]        req_ep,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         ctx_addr,
    output logic                      ctx_addr_vld,
    output logic                      dec_run,
    output logic                      EPMode,
    input  logic                      dec_rdy,
    input  logic                      ruiBin,
    input  logic                      ruiBin_vld,
    output logic                      bin_out,
    output logic [NUM_REQ-1:0]        bin_vld,
    output logic                      busy,
    output logic                      err_overflow,
    output logic                      err_spurious
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    t_state_bin_arb     r_state;
    logic [NUM_REQ-1:0] r_pend;
    logic [ADDR_W-1:0]  r_addr [NUM_REQ];
    logic [NUM_REQ-1:0] r_ep;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] w_clr;
    logic [NUM_REQ-1:0] w_take;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        f_onehot      = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    qdec_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pend   (r_pend),
        .rr_ptr (r_rr_ptr),
        .found  (w_found),
        .idx    (w_pick)
    );

    // Pending bits cleared this cycle: all on flush, else the owner on bin return
    always_comb begin
        w_clr = '0;
        if (flush) begin
            w_clr = '1;
        end else if (r_state == WAIT_BIN_BARB && ruiBin_vld) begin
            w_clr[r_owner] = 1'b1;
        end
    end

    // A request is accepted unless its slot is still occupied and not being freed
    always_comb begin
        w_take = req_run & ~(r_pend & ~w_clr);
    end

    // Pending flags and overflow detection; a new request beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= '0;
            err_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_take[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (req_run[i]) begin
                    err_overflow <= 1'b1;
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Per-requester context address and EP flag, latched only on accepted requests
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_take[i]) begin
                r_addr[i] <= req_ctx_addr[i*ADDR_W +: ADDR_W];
                r_ep[i]   <= req_ep[i];
            end
        end
    end

    // Grant FSM: issue to the engine, wait for the bin, route it or drain it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE_BARB;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            dec_run      <= 1'b0;
            ctx_addr_vld <= 1'b0;
            ctx_addr     <= '0;
            EPMode       <= 1'b0;
            bin_out      <= 1'b0;
            bin_vld      <= '0;
            err_spurious <= 1'b0;
        end else begin
            dec_run      <= 1'b0;
            ctx_addr_vld <= 1'b0;
            bin_vld      <= '0;
            case (r_state)
                IDLE_BARB: begin
                    if (ruiBin_vld) begin
                        err_spurious <= 1'b1;
                    end
                    if (!flush && w_found && dec_rdy) begin
                        r_owner      <= w_pick;
                        dec_run      <= 1'b1;
                        ctx_addr_vld <= 1'b1;
                        ctx_addr     <= r_addr[w_pick];
                        EPMode       <= r_ep[w_pick];
                        r_state      <= WAIT_BIN_BARB;
                    end
                end
                WAIT_BIN_BARB: begin
                    if (ruiBin_vld) begin
                        bin_out  <= ruiBin;
                        bin_vld  <= f_onehot(r_owner);
                        r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
                        r_state  <= IDLE_BARB;
                    end else if (flush) begin
                        r_state <= DRAIN_BARB;
                    end
                end
                DRAIN_BARB: begin
                    if (ruiBin_vld) begin
                        r_state <= IDLE_BARB;
                    end
                end
                default: r_state <= IDLE_BARB;
            endcase
        end
    end

    assign busy = (|r_pend) || (r_state != IDLE_BARB);

endmodule

// File: tb/tb_qdec_bin_arbiter.sv
// Directed testbench for qdec_bin_arbiter (NUM_REQ=3, ADDR_W=10).
module tb_qdec_bin_arbiter;
    import qdec_cabac_package::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_run;
    logic [NUM_REQ*ADDR_W-1:0] req_ctx_addr;
    logic [NUM_REQ-1:0]        req_ep;
    logic                      flush;
    logic [ADDR_W-1:0]         ctx_addr;
    logic                      ctx_addr_vld;
    logic                      dec_run;
    logic                      EPMode;
    logic                      dec_rdy;
    logic                      ruiBin;
    logic                      ruiBin_vld;
    logic                      bin_out;
    logic [NUM_REQ-1:0]        bin_vld;
    logic                      busy;
    logic                      err_overflow;
    logic                      err_spurious;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qdec_bin_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_run      (req_run),
        .req_ctx_addr (req_ctx_addr),
        .req_ep       (req_ep),
        .flush        (flush),
        .ctx_addr     (ctx_addr),
        .ctx_addr_vld (ctx_addr_vld),
        .dec_run      (dec_run),
        .EPMode       (EPMode),
        .dec_rdy      (dec_rdy),
        .ruiBin       (ruiBin),
        .ruiBin_vld   (ruiBin_vld),
        .bin_out      (bin_out),
        .bin_vld      (bin_vld),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_spurious (err_spurious)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_run      = '0;
        req_ctx_addr = '0;
        req_ep       = '0;
        flush        = 1'b0;
        dec_rdy      = 1'b1;
        ruiBin       = 1'b0;
        ruiBin_vld   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic ep);
        req_run[i]                        = 1'b1;
        req_ctx_addr[i*ADDR_W +: ADDR_W]  = a;
        req_ep[i]                         = ep;
    endtask

    // Bounded wait for the next dec_run pulse; ok=0 when the budget runs out
    task automatic wait_dec_run(output bit ok);
        int n;
        n = 0;
        while (dec_run !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        ok = (dec_run === 1'b1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        total++;
        if ({dec_run, ctx_addr_vld, ctx_addr, EPMode, bin_out, bin_vld} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {dec_run, ctx_addr_vld, ctx_addr, EPMode, bin_out, bin_vld});
        end
        total++;
        if ({busy, err_overflow, err_spurious} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {busy, err_overflow, err_spurious});
        end
        cyc();
    endtask

    task automatic test_single();
        idle_inputs();
        set_req(REQ_TRAFO, 10'h05A, 1'b0);
        cyc();
        req_run = '0;
        total++;
        if (dec_run !== 1'b0) begin
            bad++;
            $display("FAIL single_early_run got=%b exp=0", dec_run);
        end
        cyc();
        total++;
        if ({dec_run, ctx_addr_vld, ctx_addr, EPMode, busy} !== {1'b1, 1'b1, 10'h05A, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL single_issue got=%b/%b/%h/%b/%b exp=1/1/05a/0/1",
                     dec_run, ctx_addr_vld, ctx_addr, EPMode, busy);
        end
        cyc();
        total++;
        if ({dec_run, ctx_addr_vld, ctx_addr} !== {1'b0, 1'b0, 10'h05A}) begin
            bad++;
            $display("FAIL single_wait got=%b/%b/%h exp=0/0/05a", dec_run, ctx_addr_vld, ctx_addr);
        end
        ruiBin     = 1'b1;
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if ({bin_vld, bin_out} !== {3'b010, 1'b1}) begin
            bad++;
            $display("FAIL single_return got=%b/%b exp=010/1", bin_vld, bin_out);
        end
        cyc();
        total++;
        if ({bin_vld, busy} !== {3'b000, 1'b0}) begin
            bad++;
            $display("FAIL single_after got=%b/%b exp=000/0", bin_vld, busy);
        end
    endtask

    task automatic test_contention();
        int exp_idx [5];
        bit ok;
        exp_idx = '{0, 1, 2, 0, 2};
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        set_req(0, 10'h100, 1'b0);
        set_req(1, 10'h101, 1'b1);
        set_req(2, 10'h102, 1'b0);
        cyc();
        req_run = '0;
        for (int g = 0; g < 5; g++) begin
            if (g == 3) begin
                set_req(0, 10'h100, 1'b0);
                set_req(2, 10'h102, 1'b0);
                cyc();
                req_run = '0;
            end
            wait_dec_run(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL contention_timeout grant=%0d got=no_dec_run exp=dec_run", g);
            end
            total++;
            if (ctx_addr !== 10'h100 + 10'(exp_idx[g])) begin
                bad++;
                $display("FAIL contention_order grant=%0d got=%h exp=%h", g, ctx_addr, 10'h100 + 10'(exp_idx[g]));
            end
            cyc();
            cyc();
            cyc();
            ruiBin     = (g == 1);
            ruiBin_vld = 1'b1;
            cyc();
            ruiBin_vld = 1'b0;
            total++;
            if ({bin_vld, bin_out} !== {3'(1 << exp_idx[g]), (g == 1)}) begin
                bad++;
                $display("FAIL contention_route grant=%0d got=%b/%b exp=%b/%b",
                         g, bin_vld, bin_out, 3'(1 << exp_idx[g]), (g == 1));
            end
        end
        cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL contention_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        idle_inputs();
        set_req(REQ_TU, 10'h222, 1'b0);
        cyc();
        req_run = '0;
        wait_dec_run(ok);
        total++;
        if (!ok || ctx_addr !== 10'h222) begin
            bad++;
            $display("FAIL rereq_first got=%b/%h exp=1/222", ok, ctx_addr);
        end
        cyc();
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if (bin_vld !== 3'b100) begin
            bad++;
            $display("FAIL rereq_ret1 got=%b exp=100", bin_vld);
        end
        set_req(REQ_TU, 10'h2A2, 1'b1);
        cyc();
        req_run = '0;
        total++;
        if ({dec_run, busy} !== 2'b01) begin
            bad++;
            $display("FAIL rereq_pending got=%b/%b exp=0/1", dec_run, busy);
        end
        cyc();
        total++;
        if ({dec_run, ctx_addr, EPMode} !== {1'b1, 10'h2A2, 1'b1}) begin
            bad++;
            $display("FAIL rereq_second got=%b/%h/%b exp=1/2a2/1", dec_run, ctx_addr, EPMode);
        end
        cyc();
        // Request again in the very cycle the engine returns this bin
        ruiBin_vld = 1'b1;
        ruiBin     = 1'b1;
        set_req(REQ_TU, 10'h2B3, 1'b0);
        cyc();
        ruiBin_vld = 1'b0;
        req_run    = '0;
        total++;
        if ({bin_vld, bin_out, busy} !== {3'b100, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rereq_ret2 got=%b/%b/%b exp=100/1/1", bin_vld, bin_out, busy);
        end
        cyc();
        total++;
        if ({dec_run, ctx_addr, err_overflow} !== {1'b1, 10'h2B3, 1'b0}) begin
            bad++;
            $display("FAIL rereq_b2b got=%b/%h/%b exp=1/2b3/0", dec_run, ctx_addr, err_overflow);
        end
        cyc();
        ruiBin_vld = 1'b1;
        ruiBin     = 1'b0;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if ({bin_vld, bin_out, err_overflow} !== {3'b100, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rereq_ret3 got=%b/%b/%b exp=100/0/0", bin_vld, bin_out, err_overflow);
        end
        cyc();
    endtask

    task automatic test_overflow_spurious();
        bit ok;
        idle_inputs();
        dec_rdy = 1'b0;
        set_req(REQ_CU, 10'h0AA, 1'b0);
        cyc();
        req_run = '0;
        cyc();
        set_req(REQ_CU, 10'h0BB, 1'b1);
        cyc();
        req_run = '0;
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_flag got=%b exp=1", err_overflow);
        end
        cyc();
        total++;
        if ({dec_run, busy} !== 2'b01) begin
            bad++;
            $display("FAIL overflow_hold got=%b/%b exp=0/1", dec_run, busy);
        end
        dec_rdy = 1'b1;
        wait_dec_run(ok);
        total++;
        if (!ok || {ctx_addr, EPMode} !== {10'h0AA, 1'b0}) begin
            bad++;
            $display("FAIL overflow_first_addr got=%b/%h/%b exp=1/0aa/0", ok, ctx_addr, EPMode);
        end
        cyc();
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if (bin_vld !== 3'b001) begin
            bad++;
            $display("FAIL overflow_ret got=%b exp=001", bin_vld);
        end
        cyc();
        ruiBin     = 1'b1;
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if ({err_spurious, bin_vld} !== {1'b1, 3'b000}) begin
            bad++;
            $display("FAIL spurious got=%b/%b exp=1/000", err_spurious, bin_vld);
        end
        cyc();
        total++;
        if ({err_spurious, err_overflow, bin_vld, busy} !== {1'b1, 1'b1, 3'b000, 1'b0}) begin
            bad++;
            $display("FAIL spurious_sticky got=%b/%b/%b/%b exp=1/1/000/0", err_spurious, err_overflow, bin_vld, busy);
        end
    endtask

    task automatic test_flush();
        bit ok;
        idle_inputs();
        set_req(1, 10'h111, 1'b0);
        cyc();
        req_run = '0;
        wait_dec_run(ok);
        total++;
        if (!ok || ctx_addr !== 10'h111) begin
            bad++;
            $display("FAIL flush_issue got=%b/%h exp=1/111", ok, ctx_addr);
        end
        set_req(0, 10'h010, 1'b0);
        set_req(2, 10'h212, 1'b1);
        cyc();
        req_run = '0;
        flush   = 1'b1;
        cyc();
        flush   = 1'b0;
        total++;
        if ({busy, dec_run} !== 2'b10) begin
            bad++;
            $display("FAIL flush_drain got=%b/%b exp=1/0", busy, dec_run);
        end
        cyc();
        ruiBin     = 1'b1;
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if ({bin_vld, busy} !== {3'b000, 1'b0}) begin
            bad++;
            $display("FAIL flush_discard got=%b/%b exp=000/0", bin_vld, busy);
        end
        cyc();
        cyc();
        total++;
        if ({dec_run, busy} !== 2'b00) begin
            bad++;
            $display("FAIL flush_no_issue got=%b/%b exp=0/0", dec_run, busy);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        idle_inputs();
        set_req(2, 10'h3FF, 1'b1);
        cyc();
        req_run = '0;
        wait_dec_run(ok);
        cyc();
        total++;
        if (!ok || {ctx_addr, EPMode, busy} !== {10'h3FF, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rstmid_pre got=%b/%h/%b/%b exp=1/3ff/1/1", ok, ctx_addr, EPMode, busy);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if ({dec_run, ctx_addr_vld, ctx_addr, EPMode, bin_out, bin_vld, busy, err_overflow, err_spurious} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear got=%h exp=0",
                     {dec_run, ctx_addr_vld, ctx_addr, EPMode, bin_out, bin_vld, busy, err_overflow, err_spurious});
        end
        cyc();
        ruiBin     = 1'b1;
        ruiBin_vld = 1'b1;
        cyc();
        ruiBin_vld = 1'b0;
        total++;
        if ({err_spurious, err_overflow, bin_vld, bin_out} !== {1'b1, 1'b0, 3'b000, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_late_bin got=%b/%b/%b/%b exp=1/0/000/0", err_spurious, err_overflow, bin_vld, bin_out);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_overflow_spurious();
        test_flush();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
